request_unit_rr: RTL



---
 rtl/request_unit_rr_if.sv | 45 ++++
 rtl/request_unit_rr.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/request_unit_rr_if.sv
// Bundle between the request unit, its pipeline request sources and the
// instruction/data memory ports.
interface request_unit_rr_if #(
  parameter int NCH = 2,
  parameter int AW  = 32,
  parameter int DW  = 32
);
  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

  logic            ihit;
  logic            dhit;
  logic [NCH-1:0]    req_ren;
  logic [NCH-1:0]    req_wen;
  logic [NCH*AW-1:0] req_addr;
  logic [NCH*DW-1:0] req_wdat;
  logic            imemREN;
  logic            dmemREN;
  logic            dmemWEN;
  logic [AW-1:0]   dmemaddr;
  logic [DW-1:0]   dmemstore;
  logic [IW-1:0]   grant_id;
  logic [NCH-1:0]  done;
  logic            timeout_err;
  logic            busy;

  modport master (
    input  ihit, dhit,
    input  req_ren, req_wen,
    input  req_addr, req_wdat,
    output imemREN, dmemREN, dmemWEN,
    output dmemaddr, dmemstore,
    output grant_id, done,
    output timeout_err, busy
  );

  modport slave (
    output ihit, dhit,
    output req_ren, req_wen,
    output req_addr, req_wdat,
    input  imemREN, dmemREN, dmemWEN,
    input  dmemaddr, dmemstore,
    input  grant_id, done,
    input  timeout_err, busy
  );
endinterface

// File: rtl/request_unit_rr.sv
// Round-robin data request unit: arbitrates NCH request sources onto one
// data-memory port, holds each access until dhit, optional watchdog abort.
module request_unit_rr #(
  parameter int NCH          = 2,
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int TIMEOUT      = 255,
  parameter int IFETCH_STALL = 0,
  parameter int IW           = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic CLK,
  input  logic nRST,
  request_unit_rr_if.master bus
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LIMIT =
    CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  state_t          r_state;
  logic            r_ren;
  logic            r_wen;
  logic [AW-1:0]   r_addr;
  logic [DW-1:0]   r_store;
  logic [IW-1:0]   r_grant;
  logic [IW-1:0]   r_ptr;
  logic [NCH-1:0]  r_done;
  logic            r_terr;
  logic            r_busy;
  logic [CW-1:0]   r_cnt;

  logic [NCH-1:0]  w_req;
  logic            w_any;
  logic [IW-1:0]   w_sel;
  logic [AW-1:0]   w_addr;
  logic [DW-1:0]   w_wdat;
  logic            w_ren;
  logic            w_wen;
  logic [IW-1:0]   w_nxt;
  logic            w_expire;

  assign w_req = bus.req_ren | bus.req_wen;

  // Scan offsets from farthest to nearest so the nearest requester wins;
  // the j+NCH term handles wrap for any NCH.
  always_comb begin
    w_any = 1'b0;
    w_sel = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      for (int j = 0; j < NCH; j++) begin
        if (w_req[j] &&
            ((int'(r_ptr) + i == j) ||
             (int'(r_ptr) + i == j + NCH))) begin
          w_any = 1'b1;
          w_sel = IW'(j);
        end
      end
    end
  end

  always_comb begin
    w_addr = '0;
    w_wdat = '0;
    w_ren  = 1'b0;
    w_wen  = 1'b0;
    for (int j = 0; j < NCH; j++) begin
      if (w_sel == IW'(j)) begin
        w_addr = bus.req_addr[j*AW +: AW];
        w_wdat = bus.req_wdat[j*DW +: DW];
        w_ren  = bus.req_ren[j];
        w_wen  = bus.req_wen[j];
      end
    end
  end

  assign w_nxt = (r_grant == IW'(NCH - 1)) ?
                 '0 : r_grant + IW'(1);

  assign w_expire = (TIMEOUT != 0) && (r_cnt == LIMIT);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= IDLE;
      r_ren   <= 1'b0;
      r_wen   <= 1'b0;
      r_addr  <= '0;
      r_store <= '0;
      r_grant <= '0;
      r_ptr   <= '0;
      r_done  <= '0;
      r_terr  <= 1'b0;
      r_busy  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_done <= '0;
      r_terr <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (bus.ihit && w_any) begin
            r_grant <= w_sel;
            r_addr  <= w_addr;
            r_store <= w_wdat;
            r_wen   <= w_wen;
            r_ren   <= w_ren & ~w_wen;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (bus.dhit) begin
            r_ren   <= 1'b0;
            r_wen   <= 1'b0;
            r_done  <= NCH'(1) << r_grant;
            r_ptr   <= w_nxt;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else if (w_expire) begin
            r_ren   <= 1'b0;
            r_wen   <= 1'b0;
            r_terr  <= 1'b1;
            r_ptr   <= w_nxt;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else if (r_cnt != {CW{1'b1}}) begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.imemREN     = (IFETCH_STALL != 0) ? ~r_busy : 1'b1;
  assign bus.dmemREN     = r_ren;
  assign bus.dmemWEN     = r_wen;
  assign bus.dmemaddr    = r_addr;
  assign bus.dmemstore   = r_store;
  assign bus.grant_id    = r_grant;
  assign bus.done        = r_done;
  assign bus.timeout_err = r_terr;
  assign bus.busy        = r_busy;

endmodule
